// File: rtl/pipe_scoreboard_pkg.sv
// Shared definitions for the pipeline register scoreboard: forwarding-select
// encodings and default register-file / latency sizes.
package pipe_scoreboard_pkg;

    localparam int DEF_NREGS   = 32;
    localparam int DEF_MAX_LAT = 8;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_BYP = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/pipe_scoreboard_sb_entry.sv
// One scoreboard slot: pending bit plus result-ready countdown, with
// set (new producer), writeback clear and kill (flush) controls.
module sb_entry #(
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set,
    input  logic [LW-1:0] set_cnt,
    input  logic          wb_clr,
    input  logic          kill,
    output logic          pending,
    output logic [LW-1:0] cnt,
    output logic          pend_nxt
);

    localparam logic [LW-1:0] ONE = LW'(1);

    logic [LW-1:0] cnt_nxt;

    // Kill beats set beats writeback; the countdown saturates at zero.
    always_comb begin
        pend_nxt = pending;
        cnt_nxt  = cnt;
        if (pending && (cnt != '0)) cnt_nxt = cnt - ONE;
        if (wb_clr) begin
            pend_nxt = 1'b0;
            cnt_nxt  = '0;
        end
        if (set) begin
            pend_nxt = 1'b1;
            cnt_nxt  = set_cnt;
        end
        if (kill) begin
            pend_nxt = 1'b0;
            cnt_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            cnt     <= '0;
        end else begin
            pending <= pend_nxt;
            cnt     <= cnt_nxt;
        end
    end

endmodule

// File: rtl/pipe_scoreboard.sv
// In-order issue scoreboard: tracks outstanding register results, raises
// RAW/WAW stalls and picks the forwarding source for each operand.
module pipe_scoreboard
    import pipe_scoreboard_pkg::*;
#(
    parameter  int NREGS   = DEF_NREGS,
    parameter  int MAX_LAT = DEF_MAX_LAT,
    localparam int AW      = $clog2(NREGS),
    localparam int LW      = $clog2(MAX_LAT + 1),
    localparam int CW      = $clog2(NREGS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rs,
    input  logic [AW-1:0] issue_rt,
    input  logic          issue_use_rs,
    input  logic          issue_use_rt,
    input  logic          issue_wr_en,
    input  logic [AW-1:0] issue_rd,
    input  logic [LW-1:0] issue_lat,
    input  logic          kill_last,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_rd,
    output logic          issue_stall,
    output logic [1:0]    fwd_rs,
    output logic [1:0]    fwd_rt,
    output logic [CW-1:0] pending_cnt,
    output logic          err
);

    localparam logic [LW-1:0] MAX_L = LW'(MAX_LAT);
    localparam logic [LW-1:0] ONE   = LW'(1);

    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;
    logic [LW-1:0]    cnt [NREGS];
    logic [LW-1:0]    eff_lat;
    logic [CW-1:0]    cnt_nxt_pop;
    logic [AW-1:0]    last_rd;
    logic             last_valid;
    logic             rs_live, rs_wb, rs_busy;
    logic             rt_live, rt_wb, rt_busy;
    logic             waw, stall_raw, accept_set, kill_hit;

    always_comb begin
        if (issue_lat == '0)       eff_lat = ONE;
        else if (issue_lat > MAX_L) eff_lat = MAX_L;
        else                       eff_lat = issue_lat;
    end

    assign rs_live = issue_valid & issue_use_rs & (issue_rs != '0);
    assign rs_wb   = wb_valid & (wb_rd == issue_rs);
    assign rs_busy = pend[issue_rs] & (cnt[issue_rs] != '0);
    assign rt_live = issue_valid & issue_use_rt & (issue_rt != '0);
    assign rt_wb   = wb_valid & (wb_rd == issue_rt);
    assign rt_busy = pend[issue_rt] & (cnt[issue_rt] != '0);

    // WAW looks only at registered state: a same-cycle writeback does not free rd.
    assign waw       = issue_valid & issue_wr_en & (issue_rd != '0) & pend[issue_rd];
    assign stall_raw = (rs_live & rs_busy & ~rs_wb) | (rt_live & rt_busy & ~rt_wb) | waw;

    // Issue handshake: the decode instruction is accepted on a rising edge where
    // issue_valid=1 and issue_stall=0; while stalled it must be held unchanged.
    assign issue_stall = rst_n & stall_raw;
    assign accept_set  = issue_valid & ~stall_raw & issue_wr_en & (issue_rd != '0);
    assign kill_hit    = kill_last & last_valid;

    always_comb begin
        fwd_rs = FWD_RF;
        fwd_rt = FWD_RF;
        if (rst_n && rs_live) begin
            if (rs_wb)                              fwd_rs = FWD_WB;
            else if (pend[issue_rs] && !rs_busy)    fwd_rs = FWD_BYP;
        end
        if (rst_n && rt_live) begin
            if (rt_wb)                              fwd_rt = FWD_WB;
            else if (pend[issue_rt] && !rt_busy)    fwd_rt = FWD_BYP;
        end
    end

    assign pend[0]     = 1'b0;
    assign pend_nxt[0] = 1'b0;
    assign cnt[0]      = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_entry
        sb_entry #(.LW(LW)) u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .set      (accept_set && (issue_rd == AW'(i))),
            .set_cnt  (eff_lat - ONE),
            .wb_clr   (wb_valid && (wb_rd == AW'(i))),
            .kill     (kill_hit && (last_rd == AW'(i))),
            .pending  (pend[i]),
            .cnt      (cnt[i]),
            .pend_nxt (pend_nxt[i])
        );
    end

    always_comb begin
        cnt_nxt_pop = '0;
        for (int k = 0; k < NREGS; k++) cnt_nxt_pop = cnt_nxt_pop + CW'(pend_nxt[k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_valid  <= 1'b0;
            last_rd     <= '0;
            err         <= 1'b0;
            pending_cnt <= '0;
        end else begin
            last_valid  <= accept_set;
            last_rd     <= issue_rd;
            pending_cnt <= cnt_nxt_pop;
            if (wb_valid && (wb_rd != '0) && !pend[wb_rd]) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard: directed scenarios then random traffic, all
// checked against a cycle-stamp reference model of register readiness.
module tb_pipe_scoreboard;
    import pipe_scoreboard_pkg::*;

    localparam int NREGS   = 32;
    localparam int MAX_LAT = 8;
    localparam int AW      = $clog2(NREGS);
    localparam int LW      = $clog2(MAX_LAT + 1);
    localparam int CW      = $clog2(NREGS + 1);

    logic          clk;
    logic          rst_n;
    logic          issue_valid;
    logic [AW-1:0] issue_rs, issue_rt, issue_rd, wb_rd;
    logic          issue_use_rs, issue_use_rt, issue_wr_en;
    logic [LW-1:0] issue_lat;
    logic          kill_last, wb_valid;
    logic          issue_stall;
    logic [1:0]    fwd_rs, fwd_rt;
    logic [CW-1:0] pending_cnt;
    logic          err;

    pipe_scoreboard #(.NREGS(NREGS), .MAX_LAT(MAX_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_use_rs (issue_use_rs),
        .issue_use_rt (issue_use_rt),
        .issue_wr_en  (issue_wr_en),
        .issue_rd     (issue_rd),
        .issue_lat    (issue_lat),
        .kill_last    (kill_last),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .issue_stall  (issue_stall),
        .fwd_rs       (fwd_rs),
        .fwd_rt       (fwd_rt),
        .pending_cnt  (pending_cnt),
        .err          (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A register is pending from acceptance until writeback/kill; its result is
    // forwardable once the current cycle reaches issue_cycle + effective latency.
    bit m_pend  [NREGS];
    int m_ready [NREGS];
    int m_cyc;
    bit m_err;
    bit m_lv;
    int m_lrd;

    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int eff(input int lat);
        if (lat == 0) return 1;
        if (lat > MAX_LAT) return MAX_LAT;
        return lat;
    endfunction

    function automatic logic [2:0] src_eval(input bit use_b, input int a);
        bit live, wbhit, busy, st;
        logic [1:0] f;
        live  = issue_valid && use_b && a != 0;
        wbhit = wb_valid && int'(wb_rd) == a;
        busy  = m_pend[a] && m_cyc < m_ready[a];
        st    = live && busy && !wbhit;
        f     = 2'd0;
        if (live && wbhit) f = 2'd2;
        else if (live && m_pend[a] && !busy) f = 2'd1;
        return {st, f};
    endfunction

    function automatic bit model_stall();
        logic [2:0] a, b;
        bit waw;
        a   = src_eval(issue_use_rs, int'(issue_rs));
        b   = src_eval(issue_use_rt, int'(issue_rt));
        waw = issue_valid && issue_wr_en && issue_rd != 0 && m_pend[int'(issue_rd)];
        return a[2] || b[2] || waw;
    endfunction

    function automatic int model_pop();
        int p = 0;
        for (int i = 0; i < NREGS; i++) p += int'(m_pend[i]);
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_pend[i]  = 1'b0;
            m_ready[i] = 0;
        end
        m_err = 1'b0;
        m_lv  = 1'b0;
        m_lrd = 0;
    endtask

    task automatic model_edge(input bit st);
        bit set;
        int rd;
        rd  = int'(issue_rd);
        set = issue_valid && !st && issue_wr_en && rd != 0;
        if (wb_valid && wb_rd != 0 && !m_pend[int'(wb_rd)]) m_err = 1'b1;
        if (wb_valid) m_pend[int'(wb_rd)] = 1'b0;
        if (set) begin
            m_pend[rd]  = 1'b1;
            m_ready[rd] = m_cyc + eff(int'(issue_lat));
        end
        if (kill_last && m_lv) m_pend[m_lrd] = 1'b0;
        m_lv  = set;
        m_lrd = rd;
        m_cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic clr_in();
        issue_valid  = 1'b0;
        issue_rs     = '0;
        issue_rt     = '0;
        issue_use_rs = 1'b0;
        issue_use_rt = 1'b0;
        issue_wr_en  = 1'b0;
        issue_rd     = '0;
        issue_lat    = '0;
        kill_last    = 1'b0;
        wb_valid     = 1'b0;
        wb_rd        = '0;
    endtask

    task automatic drv_issue(input int rd, input int lat);
        issue_valid = 1'b1;
        issue_wr_en = 1'b1;
        issue_rd    = AW'(rd);
        issue_lat   = LW'(lat);
    endtask

    task automatic drv_wb(input int rd);
        wb_valid = 1'b1;
        wb_rd    = AW'(rd);
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle(input string tag);
        logic [2:0] a, b;
        bit st;
        #1;
        a  = src_eval(issue_use_rs, int'(issue_rs));
        b  = src_eval(issue_use_rt, int'(issue_rt));
        st = model_stall();
        check({tag, "_stall"}, 32'(issue_stall), 32'(st));
        check({tag, "_fwd_rs"}, 32'(fwd_rs), 32'(a[1:0]));
        check({tag, "_fwd_rt"}, 32'(fwd_rt), 32'(b[1:0]));
        @(posedge clk);
        model_edge(st);
        #1;
        check({tag, "_pcnt"}, 32'(pending_cnt), 32'(model_pop()));
        check({tag, "_err"}, 32'(err), 32'(m_err));
        @(negedge clk);
        clr_in();
    endtask

    // ---------------- stimulus ----------------
    int pl[$];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_cyc = 0;
        model_reset();
        clr_in();
        rst_n = 1'b0;
        #12;
        check("rst_pcnt", 32'(pending_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_stall", 32'(issue_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("idle");

        // lat=1 result is forwardable from the bypass the very next cycle
        drv_issue(5, 1);
        cycle("r37_iss");
        issue_valid = 1'b1; issue_use_rs = 1'b1; issue_rs = AW'(5);
        #1;
        check("r37_stall", 32'(issue_stall), 32'd0);
        check("r37_fwd", 32'(fwd_rs), 32'(FWD_BYP));
        cycle("r37_use");
        drv_wb(5);
        cycle("r37_wb");

        // lat=3: two stall cycles then bypass
        drv_issue(7, 3);
        cycle("r38_iss");
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1'b1; issue_use_rt = 1'b1; issue_rt = AW'(7);
            #1;
            check("r38_stall", 32'(issue_stall), (k < 2) ? 32'd1 : 32'd0);
            cycle("r38_use");
        end
        drv_wb(7);
        cycle("r38_wb");

        // WAW: held until the writeback edge has passed
        drv_issue(9, 4);
        cycle("r39_iss");
        drv_issue(9, 2);
        #1 check("r39_waw", 32'(issue_stall), 32'd1);
        cycle("r39_waw");
        drv_issue(9, 2); drv_wb(9);
        #1 check("r39_waw_wb", 32'(issue_stall), 32'd1);
        cycle("r39_waw_wb");
        drv_issue(9, 2);
        #1 check("r39_free", 32'(issue_stall), 32'd0);
        cycle("r39_free");
        drv_wb(9);
        cycle("r39_clean");

        // kill of the previous acceptance, then writeback to the killed register
        drv_issue(4, 2);
        cycle("r40_iss");
        kill_last = 1'b1;
        cycle("r40_kill");
        check("r40_pcnt0", 32'(pending_cnt), 32'd0);
        drv_wb(4);
        cycle("r40_wb");
        check("r40_err", 32'(err), 32'd1);

        // r0 never pends; same-cycle writeback overrides a live countdown
        issue_valid = 1'b1; issue_use_rs = 1'b1; issue_rs = '0;
        cycle("r41_rs0");
        drv_issue(0, 3);
        cycle("r41_rd0");
        check("r41_pcnt", 32'(pending_cnt), 32'd0);
        drv_issue(3, 5);
        cycle("r41_iss");
        issue_valid = 1'b1; issue_use_rs = 1'b1; issue_rs = AW'(3); drv_wb(3);
        #1;
        check("r41_stall", 32'(issue_stall), 32'd0);
        check("r41_fwd", 32'(fwd_rs), 32'(FWD_WB));
        cycle("r41_wbhit");

        // asynchronous reset with five registers in flight
        for (int k = 0; k < 5; k++) begin
            drv_issue(10 + k, 6);
            cycle("r42_fill");
        end
        check("r42_five", 32'(pending_cnt), 32'd5);
        drv_issue(10, 2); issue_use_rs = 1'b1; issue_rs = AW'(11); drv_wb(11);
        #2 rst_n = 1'b0;
        #1;
        check("r42_pcnt", 32'(pending_cnt), 32'd0);
        check("r42_err", 32'(err), 32'd0);
        check("r42_stall", 32'(issue_stall), 32'd0);
        check("r42_fwd", 32'(fwd_rs), 32'(FWD_RF));
        model_reset();
        @(negedge clk);
        clr_in();
        rst_n = 1'b1;
        cycle("r42_after");

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            pl.delete();
            for (int i = 1; i < 16; i++) if (m_pend[i]) pl.push_back(i);
            issue_valid  = ($urandom_range(0, 3) != 0);
            issue_use_rs = $urandom_range(0, 1);
            issue_use_rt = $urandom_range(0, 1);
            issue_rs     = AW'($urandom_range(0, 15));
            issue_rt     = AW'($urandom_range(0, 15));
            issue_wr_en  = ($urandom_range(0, 2) != 0);
            issue_rd     = AW'($urandom_range(0, 15));
            issue_lat    = LW'($urandom_range(0, 15));
            kill_last    = ($urandom_range(0, 5) == 0);
            wb_valid     = ($urandom_range(0, 2) == 0);
            if (pl.size() != 0 && $urandom_range(0, 9) != 0)
                wb_rd = AW'(pl[$urandom_range(0, pl.size() - 1)]);
            else
                wb_rd = AW'($urandom_range(0, 15));
            if (n == 1500) begin
                model_reset();
                rst_n = 1'b0;
                #1;
                check("rnd_rst_pcnt", 32'(pending_cnt), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                clr_in();
            end
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL take parameter NREGS, default 32: number of architectural registers (power of 2, ≥4).
REQ-002 SHALL take parameter MAX_LAT, default 8: maximum result latency in cycles (≥1).
REQ-003 SHALL derive AW=$clog2(NREGS), LW=$clog2(MAX_LAT+1) and CW=$clog2(NREGS+1) as localparams.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 issue_valid  in  1  decode-stage instruction presented.
REQ-007 issue_rs, issue_rt  in  AW each  source register addresses.
REQ-008 issue_use_rs, issue_use_rt  in  1 each  source actually read.
REQ-009 issue_wr_en  in  1  instruction writes a register.
REQ-010 issue_rd  in  AW  destination register.
REQ-011 issue_lat  in  LW  cycles from issue until result is forwardable; 0 is treated as 1, and values >MAX_LAT as MAX_LAT.
REQ-012 kill_last  in  1  squash the instruction accepted in the previous cycle (branch/jump flush).
REQ-013 wb_valid  in  1  writeback occurring this cycle.
REQ-014 wb_rd  in  AW  writeback register.
REQ-015 issue_stall  out  1  combinational; hold the decode stage.
REQ-016 fwd_rs, fwd_rt  out  2 each  combinational source select: 00 register file, 01 bypass network, 10 writeback path.
REQ-017 pending_cnt  out  CW  registered number of pending registers.
REQ-018 err  out  1  sticky protocol error.

Function
REQ-019 Per register, state SHALL be: pending bit plus countdown cnt[LW].
REQ-020 Register 0 SHALL never become pending; issues with issue_rd=0 or issue_wr_en=0 SHALL leave state unchanged.
REQ-021 A source SHALL be "live" when issue_valid, its use bit is 1, and its address is nonzero.
REQ-022 A live source SHALL cause a stall if pending and cnt>0, unless wb_valid and wb_rd equal it this cycle.
REQ-023 fwd for a live source SHALL be: 10 if wb_valid and wb_rd match; else 01 if pending and cnt=0; else 00. Non-live sources SHALL give 00.
REQ-024 issue_stall SHALL also assert on WAW: issue_valid, issue_wr_en, issue_rd≠0, and pending[issue_rd] set in registered state (same-cycle writeback does not clear the hazard).
REQ-025 Acceptance = issue_valid & !issue_stall; at the next edge pending[issue_rd]=1 and cnt=eff_lat−1.
REQ-026 Each cycle, every pending entry with cnt>0 SHALL decrement; cnt SHALL saturate at 0.
REQ-027 wb_valid on a pending register SHALL clear its pending bit at the edge.
REQ-028 wb_valid with wb_rd≠0 and the register not pending SHALL set err; err SHALL clear only on reset.
REQ-029 The block SHALL record last_rd/last_valid for each acceptance that set an entry; kill_last in the following cycle SHALL clear that entry. kill_last with last_valid=0 SHALL have no effect.
REQ-030 kill_last SHALL take priority over a same-cycle acceptance or writeback to the same register; the new acceptance SHALL then be re-stalled by nothing (state cleared).
REQ-031 pending_cnt SHALL equal the popcount of pending bits after each edge.
REQ-032 Outputs SHALL have zero latency from inputs to issue_stall/fwd; all state updates take effect at the next edge.

Reset
REQ-033 On reset low, asynchronously: all pending=0, cnt=0, last_valid=0, err=0, pending_cnt=0.
REQ-034 During reset, issue_stall=0 and fwd=00; reset mid-operation SHALL discard all in-flight entries.

Structure
REQ-035 A shared package SHALL hold the fwd encoding constants (FWD_RF, FWD_BYP, FWD_WB) and the default NREGS and MAX_LAT values.
REQ-036 One sub-module, sb_entry (pending bit + countdown + set/clear/kill logic), SHALL be instantiated NREGS−1 times via generate.

Verification
REQ-037 Issue rd=5 with lat=1; next cycle, a source rs=5 -> stall=0, fwd_rs=01.
REQ-038 Issue rd=7 with lat=3; following cycles, rt=7 -> stall for 2 cycles, then fwd_rt=01 on the third.
REQ-039 Pending rd=9 while issuing rd=9 -> stall=1 (WAW); assert wb_rd=9 -> stall drops the next cycle.
REQ-040 Accept rd=4, then kill_last -> pending_cnt returns to 0; wb_rd=4 afterward -> err=1.
REQ-041 Source rs=0 or issue_rd=0 -> never stalls, pending_cnt unchanged; wb_rd=3 with rs=3 in the same cycle while cnt>0 -> stall=0, fwd_rs=10.
REQ-042 Reset asserted with 5 pending entries -> pending_cnt=0 and err=0 immediately (asynchronously).
